// File: rtl/nunchuck_poll_ctrl.sv
// Nunchuck poll controller: periodically requests a 3-byte report
// (X, Y, buttons) from the link layer, collects the bytes with a per-byte
// idle timeout, and publishes the latest joystick/button state.
// Optional feature macro: NUNCHUCK_DEADZONE_EN snaps X/Y values within
// DEADZONE of centre (128) to exactly 128.
module nunchuck_poll_ctrl #(
  parameter int POLL_PERIOD = 50000,
  parameter int TIMEOUT     = 10000,
  parameter int DEADZONE    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       req_tick,
  output logic [7:0] x_val,
  output logic [7:0] y_val,
  output logic       z_but,
  output logic       ready_tick,
  output logic       timeout_tick,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam int TimerW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam int TmoW   = $clog2(TIMEOUT + 1);

  localparam logic [TimerW-1:0] TimerLast = TimerW'(POLL_PERIOD - 1);
  localparam logic [TmoW-1:0]   TmoLoad   = TmoW'(TIMEOUT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RECV = 2'd2;

`ifdef NUNCHUCK_DEADZONE_EN
  localparam bit DzEnable = 1'b1;
`else
  localparam bit DzEnable = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              pollPend_q, pollPend_d;
  logic [1:0]        idx_q, idx_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [7:0]        stage0_q, stage0_d;
  logic [7:0]        stage1_q, stage1_d;
  logic [7:0]        xVal_q, xVal_d;
  logic [7:0]        yVal_q, yVal_d;
  logic              zBut_q, zBut_d;
  logic              readyTick_q, readyTick_d;
  logic              timeoutTick_q, timeoutTick_d;
  logic [7:0]        errCnt_q, errCnt_d;
  logic              pollWrap;

  // Snap a raw axis value to centre when it lies inside the dead band;
  // the distance from 128 is taken as a 9-bit two's-complement difference.
  function automatic logic [7:0] applyDeadzone(input logic [7:0] v);
    logic [8:0] diff;
    logic [8:0] mag;
    logic [7:0] result;
    diff = {1'b0, v} - 9'd128;
    mag  = diff[8] ? (~diff + 9'd1) : diff;
    result = v;
    if (DzEnable && (mag <= 9'(DEADZONE))) begin
      result = 8'd128;
    end
    return result;
  endfunction

  assign pollWrap = en && (timer_q == TimerLast);

  // Next-state logic: poll timer, pending flag, and the IDLE/REQ/RECV sequencer.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    pollPend_d    = pollPend_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    stage0_d      = stage0_q;
    stage1_d      = stage1_q;
    xVal_d        = xVal_q;
    yVal_d        = yVal_q;
    zBut_d        = zBut_q;
    readyTick_d   = 1'b0;
    timeoutTick_d = 1'b0;
    errCnt_d      = errCnt_q;

    if (!en) begin
      timer_d = '0;
    end else if (pollWrap) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TimerW'(1);
    end

    if (!en) begin
      pollPend_d = 1'b0;
    end else begin
      if ((state_q == IDLE) && pollPend_q) begin
        pollPend_d = 1'b0;
      end
      if (pollWrap) begin
        pollPend_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (pollPend_q && en) begin
          state_d = REQ;
        end
      end
      REQ: begin
        idx_d   = 2'd0;
        tmo_d   = TmoLoad;
        state_d = RECV;
      end
      RECV: begin
        if (byte_valid) begin
          tmo_d = TmoLoad;
          case (idx_q)
            2'd0: begin
              stage0_d = byte_in;
              idx_d    = 2'd1;
            end
            2'd1: begin
              stage1_d = byte_in;
              idx_d    = 2'd2;
            end
            default: begin
              xVal_d      = applyDeadzone(stage0_q);
              yVal_d      = applyDeadzone(stage1_q);
              zBut_d      = byte_in[0];
              readyTick_d = 1'b1;
              idx_d       = 2'd0;
              state_d     = IDLE;
            end
          endcase
        end else if (tmo_q <= TmoW'(1)) begin
          timeoutTick_d = 1'b1;
          if (errCnt_q != 8'hFF) begin
            errCnt_d = errCnt_q + 8'd1;
          end
          idx_d   = 2'd0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - TmoW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset returns to a centred, idle, error-free controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      pollPend_q    <= 1'b0;
      idx_q         <= 2'd0;
      tmo_q         <= '0;
      stage0_q      <= 8'd0;
      stage1_q      <= 8'd0;
      xVal_q        <= 8'd128;
      yVal_q        <= 8'd128;
      zBut_q        <= 1'b0;
      readyTick_q   <= 1'b0;
      timeoutTick_q <= 1'b0;
      errCnt_q      <= 8'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pollPend_q    <= pollPend_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      stage0_q      <= stage0_d;
      stage1_q      <= stage1_d;
      xVal_q        <= xVal_d;
      yVal_q        <= yVal_d;
      zBut_q        <= zBut_d;
      readyTick_q   <= readyTick_d;
      timeoutTick_q <= timeoutTick_d;
      errCnt_q      <= errCnt_d;
    end
  end

  assign req_tick     = (state_q == REQ);
  assign busy         = (state_q != IDLE);
  assign x_val        = xVal_q;
  assign y_val        = yVal_q;
  assign z_but        = zBut_q;
  assign ready_tick   = readyTick_q;
  assign timeout_tick = timeoutTick_q;
  assign err_cnt      = errCnt_q;

endmodule

// File: tb/tb_nunchuck_poll_ctrl.sv
// Testbench for nunchuck_poll_ctrl with a short poll period and timeout.
// Expected packets go into a scoreboard queue as the last byte is driven
// and are popped when ready_tick appears.
module tb_nunchuck_poll_ctrl;

  localparam int PollPeriod = 8;
  localparam int Timeout    = 5;
  localparam int Deadzone   = 4;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       z;
  } pkt_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       req_tick;
  logic [7:0] x_val;
  logic [7:0] y_val;
  logic       z_but;
  logic       ready_tick;
  logic       timeout_tick;
  logic       busy;
  logic [7:0] err_cnt;

  int   errors = 0;
  int   checks = 0;
  pkt_t expQ[$];

  nunchuck_poll_ctrl #(
    .POLL_PERIOD(PollPeriod),
    .TIMEOUT    (Timeout),
    .DEADZONE   (Deadzone)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .req_tick    (req_tick),
    .x_val       (x_val),
    .y_val       (y_val),
    .z_but       (z_but),
    .ready_tick  (ready_tick),
    .timeout_tick(timeout_tick),
    .busy        (busy),
    .err_cnt     (err_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Independent model of the optional centre dead band.
  function automatic logic [7:0] dzModel(input logic [7:0] v);
`ifdef NUNCHUCK_DEADZONE_EN
    if (int'(v) >= 128 - Deadzone && int'(v) <= 128 + Deadzone) return 8'd128;
`endif
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic waitReq(output int n);
    n = 0;
    for (int i = 0; i <= 40; i++) begin
      if (req_tick) begin
        n = i;
        break;
      end
      tick();
    end
  endtask

  task automatic waitTimeout(output int n);
    n = 0;
    for (int i = 0; i <= 40; i++) begin
      if (timeout_tick) begin
        n = i;
        break;
      end
      tick();
    end
  endtask

  task automatic sendPacket(input logic [7:0] bx, input logic [7:0] by,
                            input logic [7:0] bz);
    pkt_t p;
    applyStimulus(bx);
    applyStimulus(by);
    p.x = dzModel(bx);
    p.y = dzModel(by);
    p.z = bz[0];
    expQ.push_back(p);
    applyStimulus(bz);
    checkOutput("readyPulse", ready_tick, 1);
    checkOutput("busyFall", busy, 0);
    tick();
    checkOutput("readyOnce", ready_tick, 0);
  endtask

  // Scoreboard side: pop and compare whenever the DUT announces a packet.
  always @(negedge clk) begin
    pkt_t e;
    if (ready_tick || timeout_tick) begin
      checkOutput("tickExclusive", {31'd0, ready_tick && timeout_tick}, 0);
    end
    if (ready_tick) begin
      checkOutput("queueNotEmpty", {31'd0, expQ.size() != 0}, 1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("sbX", x_val, e.x);
        checkOutput("sbY", y_val, e.y);
        checkOutput("sbZ", z_but, e.z);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int reqCount;
    rst        = 1'b0;
    en         = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #1 rst = 1'b1;
    #3;
    checkOutput("rstX", x_val, 8'd128);
    checkOutput("rstY", y_val, 8'd128);
    checkOutput("rstZ", z_but, 0);
    checkOutput("rstErr", err_cnt, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstReq", req_tick, 0);
    checkOutput("rstReady", ready_tick, 0);
    checkOutput("rstTimeout", timeout_tick, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("idleNoReq", req_tick, 0);

    // First poll timing and first packet, with a byte ignored during REQ.
    en = 1'b1;
    waitReq(n);
    checkOutput("firstReqCycles", n, PollPeriod + 1);
    checkOutput("busyInReq", busy, 1);
    checkOutput("preX", x_val, 8'd128);
    checkOutput("preErr", err_cnt, 0);
    applyStimulus(8'hEE);
    checkOutput("busyInRecv", busy, 1);
    sendPacket(8'h50, 8'hB0, 8'h01);

    // One byte then silence: timeout after TIMEOUT idle cycles.
    waitReq(n);
    checkOutput("reqSeenTmo", {31'd0, n != 0}, 1);
    tick();
    applyStimulus(8'h11);
    waitTimeout(n);
    checkOutput("tmoCycles", n, Timeout);
    checkOutput("tmoErr", err_cnt, 1);
    checkOutput("tmoX", x_val, 8'h50);
    checkOutput("tmoY", y_val, 8'hB0);
    checkOutput("tmoZ", z_but, 1);
    checkOutput("tmoBusy", busy, 0);
    tick();
    checkOutput("tmoOnce", timeout_tick, 0);

    // Third byte lands on the expiry cycle: the byte wins.
    waitReq(n);
    tick();
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    for (int i = 0; i < Timeout - 1; i++) tick();
    begin
      pkt_t p;
      p.x = dzModel(8'h22);
      p.y = dzModel(8'h33);
      p.z = 1'b0;
      expQ.push_back(p);
    end
    applyStimulus(8'h00);
    checkOutput("raceReady", ready_tick, 1);
    checkOutput("raceNoTmo", timeout_tick, 0);
    checkOutput("raceErr", err_cnt, 1);
    tick();
    checkOutput("raceLateTmo", timeout_tick, 0);

    // Dead-band patterns (raw without the feature macro).
    waitReq(n);
    tick();
    sendPacket(8'h83, 8'h7B, 8'h00);
    waitReq(n);
    tick();
    sendPacket(8'h85, 8'h7B, 8'h01);

    // Dropping en mid-transaction: packet completes, then no further polls.
    waitReq(n);
    tick();
    en = 1'b0;
    sendPacket(8'h10, 8'hF0, 8'h01);
    reqCount = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (req_tick) reqCount++;
    end
    checkOutput("enOffNoReq", reqCount, 0);
    en = 1'b1;
    waitReq(n);
    checkOutput("enOnReqCycles", n, PollPeriod + 1);

    // Error counter saturation.
    waitTimeout(n);
    checkOutput("satFirstTmo", n, Timeout + 1);
    checkOutput("satErr2", err_cnt, 2);
    for (int i = 0; i < 253; i++) begin
      waitReq(n);
      waitTimeout(n);
      checkOutput("satTmo", n, Timeout + 1);
    end
    checkOutput("satErr255", err_cnt, 255);
    waitReq(n);
    waitTimeout(n);
    tick();
    checkOutput("satHold", err_cnt, 255);
    checkOutput("satX", x_val, dzModel(8'h10));
    checkOutput("satY", y_val, dzModel(8'hF0));

    // Asynchronous reset in RECV with a byte staged.
    waitReq(n);
    tick();
    applyStimulus(8'h44);
    #2 rst = 1'b1;
    #1;
    checkOutput("arstBusy", busy, 0);
    checkOutput("arstX", x_val, 8'd128);
    checkOutput("arstY", y_val, 8'd128);
    checkOutput("arstZ", z_but, 0);
    checkOutput("arstErr", err_cnt, 0);
    tick();
    rst = 1'b0;
    waitReq(n);
    checkOutput("postRstReqCycles", n, PollPeriod + 1);
    tick();
    sendPacket(8'h60, 8'h70, 8'h00);

    checkOutput("queueEmpty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
